// File: rtl/tlb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlb_pkg: entry/page layouts, page sizes, INVTLB ops, FSM states      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tlb_pkg;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd22;

  localparam logic [4:0] INV_ALL_0      = 5'd0;
  localparam logic [4:0] INV_ALL_1      = 5'd1;
  localparam logic [4:0] INV_G1         = 5'd2;
  localparam logic [4:0] INV_G0         = 5'd3;
  localparam logic [4:0] INV_G0_ASID    = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;
  localparam logic [4:0] INV_OP_MAX     = 5'd6;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } tlb_state_e;

  // Odd/even page pick: the bit just above the page offset selects P1.
  function automatic tlb_page_t page_sel(input logic [5:0] ps, input tlb_page_t p0,
                                         input tlb_page_t p1, input logic odd_4k,
                                         input logic odd_4m);
    logic odd;
    odd = (ps == PS_4M) ? odd_4m : odd_4k;
    return odd ? p1 : p0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlb_match: combinational ASID/G and PS-dependent VPPN compare        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tlb_match
  import tlb_pkg::*;
(
  input  logic [18:0] i_vppn,
  input  logic [5:0]  i_ps,
  input  logic        i_g,
  input  logic [9:0]  i_asid,
  input  logic [18:0] i_vpn,
  input  logic [9:0]  i_cur_asid,
  input  logic        i_g_mask,
  output logic        o_asid_ok,
  output logic        o_va_eq
);

  // With i_g_mask low o_asid_ok is a plain ASID equality.
  assign o_asid_ok = (i_g_mask & i_g) | (i_asid == i_cur_asid);
  assign o_va_eq   = (i_ps == PS_4M) ? (i_vppn[18:10] == i_vpn[18:10])
                                     : (i_vppn == i_vpn);

endmodule
`default_nettype wire

// File: rtl/tlb_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlb_lookup: registered two-port TLB search, TLBWR/TLBRD, INVTLB sweep|
// | Option: TLB_LOOKUP_WR_FWD_EN forwards same-cycle writes to searches. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s0_req,
  input  logic [31:0]     s0_vaddr,
  input  logic [9:0]      s0_asid,
  input  logic            s1_req,
  input  logic [31:0]     s1_vaddr,
  input  logic [9:0]      s1_asid,
  input  logic            stall,
  output logic            lookup_ready,
  output logic            s0_valid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_pfn,
  output logic [5:0]      found_ps0,
  output logic [1:0]      s0_tlb_mat,
  output logic            s0_v,
  output logic            s0_d,
  output logic [1:0]      s0_plv,
  output logic            s1_valid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_pfn,
  output logic [5:0]      found_ps1,
  output logic [1:0]      s1_tlb_mat,
  output logic            s1_v,
  output logic            s1_d,
  output logic [1:0]      s1_plv,
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic [88:0]     w_entry,
  input  logic [IDXW-1:0] r_index,
  output logic [88:0]     r_entry,
  input  logic            inv_req,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [31:0]     inv_va,
  output logic            inv_done,
  output logic            inv_err
);

  tlb_entry_t r_tlb [TLBNUM];
  tlb_entry_t w_view [TLBNUM];
  tlb_entry_t w_wr;
  tlb_entry_t w_sw;

  tlb_state_e      r_state, w_state_nxt;
  logic            r_ready, r_done, w_ready_nxt, w_done_nxt;
  logic            w_idle, w_inv_go, r_inv_err;
  logic [IDXW-1:0] r_ptr;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_vpn;
  logic            w_sw_asid, w_sw_va, w_kill_op, w_kill;

  logic [1:0]             w_req, w_va12;
  logic [1:0][18:0]       w_vpn;
  logic [1:0][9:0]        w_asid;
  logic [1:0][TLBNUM-1:0] w_hit;
  logic [1:0]             w_found;
  logic [1:0][IDXW-1:0]   w_idx;
  logic [1:0][5:0]        w_ps;
  tlb_page_t [1:0]        w_pg;

  logic [1:0]           r_valid, r_found;
  logic [1:0][IDXW-1:0] r_idx;
  logic [1:0][5:0]      r_ps;
  tlb_page_t [1:0]      r_pg;

  logic w_unused;

  assign w_wr   = w_entry;
  assign w_idle = (r_state == ST_IDLE);
  assign w_req  = {s1_req, s0_req};
  assign w_vpn  = {s1_vaddr[31:13], s0_vaddr[31:13]};
  assign w_va12 = {s1_vaddr[12], s0_vaddr[12]};
  assign w_asid = {s1_asid, s0_asid};

  generate
    for (genvar i = 0; i < TLBNUM; i++) begin : g_view
`ifdef TLB_LOOKUP_WR_FWD_EN
      assign w_view[i] = (we && (w_index == IDXW'(i))) ? w_wr : r_tlb[i];
`else
      assign w_view[i] = r_tlb[i];
`endif
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
      for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
        logic w_asid_ok, w_va_eq;
        tlb_match u_match (
          .i_vppn     (w_view[i].vppn),
          .i_ps       (w_view[i].ps),
          .i_g        (w_view[i].g),
          .i_asid     (w_view[i].asid),
          .i_vpn      (w_vpn[p]),
          .i_cur_asid (w_asid[p]),
          .i_g_mask   (1'b1),
          .o_asid_ok  (w_asid_ok),
          .o_va_eq    (w_va_eq)
        );
        assign w_hit[p][i] = w_view[i].e & w_asid_ok & w_va_eq;
      end
    end
  endgenerate

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_found = '0;
    w_idx   = '0;
    w_ps    = '0;
    w_pg    = '0;
    for (int p = 0; p < 2; p++) begin
      if (w_idle && w_req[p]) begin
        for (int i = TLBNUM - 1; i >= 0; i--) begin
          if (w_hit[p][i]) begin
            w_found[p] = 1'b1;
            w_idx[p]   = IDXW'(i);
          end
        end
        if (w_found[p]) begin
          w_ps[p] = w_view[w_idx[p]].ps;
          w_pg[p] = page_sel(w_view[w_idx[p]].ps, w_view[w_idx[p]].p0,
                             w_view[w_idx[p]].p1, w_va12[p], w_vpn[p][9]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= '0;
      r_found <= '0;
      r_idx   <= '0;
      r_ps    <= '0;
      r_pg    <= '0;
    end else if (!stall) begin
      r_valid <= w_req & {2{w_idle}};
      r_found <= w_found;
      r_idx   <= w_idx;
      r_ps    <= w_ps;
      r_pg    <= w_pg;
    end
  end

  // A write landing on the entry under the sweep pointer is swept as written.
  assign w_sw = (we && (w_index == r_ptr)) ? w_wr : r_tlb[r_ptr];

  tlb_match u_sweep_match (
    .i_vppn     (w_sw.vppn),
    .i_ps       (w_sw.ps),
    .i_g        (w_sw.g),
    .i_asid     (w_sw.asid),
    .i_vpn      (r_inv_vpn),
    .i_cur_asid (r_inv_asid),
    .i_g_mask   (1'b0),
    .o_asid_ok  (w_sw_asid),
    .o_va_eq    (w_sw_va)
  );

  always_comb begin
    w_kill_op = 1'b0;
    case (r_inv_op)
      INV_ALL_0, INV_ALL_1: w_kill_op = 1'b1;
      INV_G1:               w_kill_op = w_sw.g;
      INV_G0:               w_kill_op = ~w_sw.g;
      INV_G0_ASID:          w_kill_op = ~w_sw.g & w_sw_asid;
      INV_G0_ASID_VA:       w_kill_op = ~w_sw.g & w_sw_asid & w_sw_va;
      INV_GA_VA:            w_kill_op = (w_sw.g | w_sw_asid) & w_sw_va;
      default:              w_kill_op = 1'b0;
    endcase
  end

  assign w_kill = (r_state == ST_SWEEP) & w_kill_op;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < TLBNUM; i++) r_tlb[i] <= '0;
    end else begin
      if (we) r_tlb[w_index] <= w_wr;
      if (w_kill) r_tlb[r_ptr].e <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_entry <= '0;
    else       r_entry <= r_tlb[r_index];
  end

  assign w_inv_go = w_idle & inv_req & (inv_op <= INV_OP_MAX);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_inv_go) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_ptr == IDXW'(TLBNUM - 1)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so reset forces them low.
  always_comb begin
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr      <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vpn  <= '0;
      r_inv_err  <= 1'b0;
    end else begin
      r_inv_err <= w_idle & inv_req & (inv_op > INV_OP_MAX);
      if (w_inv_go) begin
        r_ptr      <= '0;
        r_inv_op   <= inv_op;
        r_inv_asid <= inv_asid;
        r_inv_vpn  <= inv_va[31:13];
      end else if (r_state == ST_SWEEP) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign lookup_ready = r_ready;
  assign inv_done     = r_done;
  assign inv_err      = r_inv_err;

  assign s0_valid   = r_valid[0];
  assign s0_found   = r_found[0];
  assign s0_index   = r_idx[0];
  assign s0_pfn     = r_pg[0].ppn;
  assign found_ps0  = r_ps[0];
  assign s0_tlb_mat = r_pg[0].mat;
  assign s0_v       = r_pg[0].v;
  assign s0_d       = r_pg[0].d;
  assign s0_plv     = r_pg[0].plv;

  assign s1_valid   = r_valid[1];
  assign s1_found   = r_found[1];
  assign s1_index   = r_idx[1];
  assign s1_pfn     = r_pg[1].ppn;
  assign found_ps1  = r_ps[1];
  assign s1_tlb_mat = r_pg[1].mat;
  assign s1_v       = r_pg[1].v;
  assign s1_d       = r_pg[1].d;
  assign s1_plv     = r_pg[1].plv;

  assign w_unused = ^{s0_vaddr[11:0], s1_vaddr[11:0], inv_va[12:0], w_sw.e, w_sw.p0, w_sw.p1};

endmodule
`default_nettype wire

// File: tb/tb_tlb_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tlb_lookup: directed self-checking bench for tlb_lookup           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tlb_lookup;
  import tlb_pkg::*;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            s0_req, s1_req, stall, we, inv_req;
  logic [31:0]     s0_vaddr, s1_vaddr, inv_va;
  logic [9:0]      s0_asid, s1_asid, inv_asid;
  logic [IDXW-1:0] w_index, r_index;
  logic [88:0]     w_entry;
  logic [4:0]      inv_op;
  logic            lookup_ready, inv_done, inv_err;
  logic            s0_valid, s0_found, s0_v, s0_d, s1_valid, s1_found, s1_v, s1_d;
  logic [IDXW-1:0] s0_index, s1_index;
  logic [19:0]     s0_pfn, s1_pfn;
  logic [5:0]      found_ps0, found_ps1;
  logic [1:0]      s0_tlb_mat, s1_tlb_mat, s0_plv, s1_plv;
  logic [88:0]     r_entry;

  int vectors = 0;
  int fails   = 0;

  tlb_entry_t ent_a, ent_ag, ent_b, ent_c, ent_d, ent_e, ent_f, ent_x;
  logic       saw_done;

  tlb_lookup #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .rstn(rstn),
    .s0_req(s0_req), .s0_vaddr(s0_vaddr), .s0_asid(s0_asid),
    .s1_req(s1_req), .s1_vaddr(s1_vaddr), .s1_asid(s1_asid),
    .stall(stall), .lookup_ready(lookup_ready),
    .s0_valid(s0_valid), .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .found_ps0(found_ps0), .s0_tlb_mat(s0_tlb_mat), .s0_v(s0_v), .s0_d(s0_d), .s0_plv(s0_plv),
    .s1_valid(s1_valid), .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .found_ps1(found_ps1), .s1_tlb_mat(s1_tlb_mat), .s1_v(s1_v), .s1_d(s1_d), .s1_plv(s1_plv),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry),
    .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .inv_done(inv_done), .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [88:0] obs, input logic [88:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tlb_page_t pg(logic [19:0] ppn, logic [1:0] plv, logic [1:0] mat,
                                   logic d, logic v);
    tlb_page_t p;
    p.ppn = ppn; p.plv = plv; p.mat = mat; p.d = d; p.v = v;
    return p;
  endfunction

  function automatic tlb_entry_t mk(logic [18:0] vppn, logic [5:0] ps, logic g,
                                    logic [9:0] asid, tlb_page_t p0, tlb_page_t p1);
    tlb_entry_t t;
    t.e = 1'b1; t.vppn = vppn; t.ps = ps; t.g = g; t.asid = asid; t.p0 = p0; t.p1 = p1;
    return t;
  endfunction

  task automatic wr(input logic [IDXW-1:0] idx, input tlb_entry_t ent);
    we = 1'b1; w_index = idx; w_entry = ent;
    tick();
    we = 1'b0;
  endtask

  task automatic chk_s0_zero(input string tag);
    chk({tag, "_s0_fields"}, {s0_found, s0_index, s0_pfn, found_ps0, s0_tlb_mat, s0_plv, s0_v, s0_d}, '0);
  endtask

  initial begin
    rstn = 1'b0; s0_req = 0; s1_req = 0; stall = 0; we = 0; inv_req = 0;
    s0_vaddr = 0; s1_vaddr = 0; inv_va = 0; s0_asid = 0; s1_asid = 0; inv_asid = 0;
    w_index = 0; r_index = 0; w_entry = 0; inv_op = 0;

    ent_a  = mk(19'h00040, PS_4K, 1'b0, 10'd5, pg(20'h11111, 2'd3, 2'd2, 1'b1, 1'b1),
                pg(20'hABCDE, 2'd0, 2'd1, 1'b0, 1'b1));
    ent_ag = ent_a; ent_ag.g = 1'b1;
    ent_b  = mk(19'h00400, PS_4M, 1'b1, 10'd0, pg(20'h22222, 2'd1, 2'd3, 1'b1, 1'b1),
                pg(20'h33333, 2'd2, 2'd0, 1'b0, 1'b1));
    ent_c  = mk(19'h00050, PS_4K, 1'b0, 10'd5, pg(20'h55555, 2'd0, 2'd0, 1'b0, 1'b1), '0);
    ent_d  = mk(19'h00060, PS_4K, 1'b0, 10'd7, pg(20'h66666, 2'd0, 2'd0, 1'b0, 1'b1), '0);
    ent_e  = mk(19'h00070, PS_4K, 1'b0, 10'd5, pg(20'h77777, 2'd0, 2'd0, 1'b0, 1'b1), '0);
    ent_f  = mk(19'h00080, PS_4K, 1'b0, 10'd5, pg(20'h88888, 2'd0, 2'd0, 1'b0, 1'b1), '0);

    // Reset state
    repeat (3) tick();
    chk("rst_ready", lookup_ready, 0);
    chk("rst_valid", {s0_valid, s1_valid}, 0);
    chk("rst_done_err", {inv_done, inv_err}, 0);
    chk("rst_rentry", r_entry, 0);
    rstn = 1'b1;
    tick();
    chk("ready_after_rst", lookup_ready, 1);

    // 4K hit on P1
    wr(4'd3, ent_a);
    s0_req = 1; s0_vaddr = 32'h00081000; s0_asid = 10'd5;
    tick();
    chk("a_valid_found", {s0_valid, s0_found}, 2'b11);
    chk("a_index", s0_index, 3);
    chk("a_pfn", s0_pfn, 20'hABCDE);
    chk("a_ps", found_ps0, 12);
    chk("a_mat_plv_v_d", {s0_tlb_mat, s0_plv, s0_v, s0_d}, {2'd1, 2'd0, 1'b1, 1'b0});

    // ASID mismatch -> miss with zeroed fields
    s0_asid = 10'd6;
    tick();
    chk("asid_miss_valid", s0_valid, 1);
    chk_s0_zero("asid_miss");

    // Same-cycle write returns old contents, next request sees it
    we = 1; w_index = 4'd3; w_entry = ent_ag;
    tick();
    we = 0;
    chk("wr_same_cycle_old", s0_found, 0);
    tick();
    chk("g_hit_found", s0_found, 1);
    chk("g_hit_pfn", s0_pfn, 20'hABCDE);
    s0_req = 0;

    r_index = 4'd3;
    tick();
    chk("tlbrd_idx3", r_entry, ent_ag);

    // 4M entry, even page
    wr(4'd7, ent_b);
    s1_req = 1; s1_vaddr = 32'h00800000; s1_asid = 10'd9;
    tick();
    chk("b_found_index", {s1_found, s1_index}, {1'b1, 4'd7});
    chk("b_pfn", s1_pfn, 20'h22222);
    chk("b_ps", found_ps1, 22);
    chk("b_mat_plv_d", {s1_tlb_mat, s1_plv, s1_d}, {2'd3, 2'd1, 1'b1});
    s1_req = 0;
    wr(4'd1, ent_b);
    s1_req = 1;
    tick();
    chk("dup_lowest_index", s1_index, 1);
    s1_vaddr = 32'h00C00000;
    tick();
    chk("b_odd_pfn_plv", {s1_pfn, s1_plv}, {20'h33333, 2'd2});
    s1_req = 0;

    // Stall holds outputs and ignores new requests
    s0_req = 1; s0_vaddr = 32'h00081000; s0_asid = 10'd6;
    tick();
    chk("pre_stall_hit", {s0_found, s0_index}, {1'b1, 4'd3});
    stall = 1; s0_vaddr = 32'h12345000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", {s0_valid, s0_found, s0_index, s0_pfn}, {1'b1, 1'b1, 4'd3, 20'hABCDE});
    end
    stall = 0; s0_req = 0;
    tick();
    chk("post_stall_idle", {s0_valid, s0_found}, 0);

    // INVTLB op 4, asid 5
    wr(4'd5, ent_c);
    wr(4'd6, ent_d);
    inv_req = 1; inv_op = 5'd4; inv_asid = 10'd5; inv_va = 0;
    tick();
    inv_req = 0;
    s0_req = 1; s0_vaddr = 32'h000A0000; s0_asid = 10'd5;
    for (int k = 0; k <= 16; k++) begin
      chk("sweep_ready_low", lookup_ready, 0);
      chk("sweep_done", inv_done, (k == 16));
      if (k == 3) chk("sweep_req_dropped", s0_valid, 0);
      if (k == 2) begin we = 1; w_index = 4'd12; w_entry = ent_e; end
      else if (k == 5) begin we = 1; w_index = 4'd0; w_entry = ent_f; end
      else we = 0;
      tick();
    end
    we = 0;
    chk("sweep_end_ready", {lookup_ready, inv_done, s0_valid}, 3'b100);
    tick();
    chk("c_removed", {s0_valid, s0_found}, 2'b10);
    s0_vaddr = 32'h000C0000; s0_asid = 10'd7;
    tick();
    chk("d_survives", {s0_found, s0_index}, {1'b1, 4'd6});
    s0_vaddr = 32'h00081000; s0_asid = 10'd5;
    tick();
    chk("g1_survives", {s0_found, s0_index}, {1'b1, 4'd3});
    s0_req = 0;
    r_index = 4'd12;
    tick();
    ent_x = ent_e; ent_x.e = 1'b0;
    chk("late_write_swept", r_entry, ent_x);
    r_index = 4'd0;
    tick();
    chk("visited_write_kept", r_entry, ent_f);

    // Illegal op
    inv_req = 1; inv_op = 5'd7;
    tick();
    inv_req = 0;
    chk("op7_err", {inv_err, lookup_ready}, 2'b11);
    tick();
    chk("op7_no_sweep", {inv_err, lookup_ready, inv_done}, 3'b010);

    // Reset mid-sweep
    inv_req = 1; inv_op = 5'd0;
    tick();
    inv_req = 0;
    repeat (3) tick();
    chk("mid_sweep_busy", lookup_ready, 0);
    rstn = 0;
    tick();
    chk("rst_mid_ctrl", {lookup_ready, inv_done, inv_err, s0_valid, s1_valid}, 0);
    chk("rst_mid_rentry", r_entry, 0);
    chk_s0_zero("rst_mid");
    tick();
    rstn = 1;
    saw_done = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (inv_done) saw_done = 1;
    end
    chk("no_done_after_abort", saw_done, 0);
    chk("ready_after_abort", lookup_ready, 1);
    s0_req = 1; s0_vaddr = 32'h00081000; s0_asid = 10'd5;
    tick();
    chk("post_rst_miss_valid", s0_valid, 1);
    chk_s0_zero("post_rst_miss");
    s0_req = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlb_lookup.md
# tlb_lookup

Registered two-port TLB search stage that sits directly upstream of the TLB output mux. It holds the TLB entry array and answers the fetch (port 0) and data (port 1) search requests one cycle after issue. Each result carries found, page frame, page size, MAT and permission bits, which the output mux consumes. It also services the TLBWR/TLBFILL write, TLBRD read and a serial INVTLB sweep.

## Interface
- TLBNUM, 16, number of entries (power of two, 4..64)
- IDXW, $clog2(TLBNUM), index width
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s{0,1}_req  in  1  search request
- s{0,1}_vaddr  in  32  virtual address
- s{0,1}_asid  in  10  current ASID
- stall  in  1  downstream stall; hold all search outputs
- lookup_ready  out  1  high when searches are accepted (IDLE)
- s{0,1}_valid  out  1  result valid
- s{0,1}_found  out  1  hit
- s{0,1}_index  out  IDXW  hit index
- s{0,1}_pfn  out  20  physical page number of the selected odd/even page
- found_ps{0,1}  out  6  page size of the hit (12 or 22)
- s{0,1}_tlb_mat  out  2  MAT
- s{0,1}_v / s{0,1}_d  out  1  valid / dirty
- s{0,1}_plv  out  2  PLV
- we  in  1  write entry
- w_index  in  IDXW  write index
- w_entry  in  89  packed entry (tlb_pkg::tlb_entry_t: E, VPPN[18:0], PS[5:0], G, ASID[9:0], P0/P1 {PPN[19:0], PLV[1:0], MAT[1:0], D, V})
- r_index  in  IDXW  read index
- r_entry  out  89  entry at r_index, registered
- inv_req  in  1  start INVTLB
- inv_op  in  5  INVTLB op
- inv_asid  in  10  ASID operand
- inv_va  in  32  VA operand
- inv_done  out  1  one-cycle pulse when a sweep completes
- inv_err  out  1  one-cycle pulse for an illegal op

## Operation
- Match, entry i: E=1, (G=1 or ASID==s_asid), VPPN compare: PS=12 uses all of VPPN vs vaddr[31:13]; PS=22 uses VPPN[18:10] vs vaddr[31:23].
- Page select: vaddr[12] for PS=12, vaddr[22] for PS=22; 0 → P0, 1 → P1.
- Multiple hits: the lowest index wins. Miss: found=0, and index, pfn, ps, mat, plv, v and d all read 0.
- Write: when we=1, entry[w_index] is updated at the clock edge. Writes are accepted in every state. A write to an entry the sweep has not yet visited is itself subject to the sweep.
- INVTLB ops, matching entries get E←0:
  - 0/1: all entries
  - 2: G=1
  - 3: G=0
  - 4: G=0 and ASID match
  - 5: G=0, ASID match and VA match
  - 6: (G=1 or ASID match) and VA match
  - VA match uses the same PS-dependent compare as search, applied to inv_va.
  - Op > 6: inv_err pulses next cycle, no sweep starts, state stays IDLE.
- FSM:
  - IDLE: inv_req with a legal op latches the operands and goes to SWEEP, ptr←0.
  - SWEEP: evaluate entry[ptr] each cycle, ptr++. After ptr==TLBNUM-1, go to DONE.
  - DONE: inv_done=1 for one cycle, then IDLE.
- lookup_ready is high only in IDLE. Requests in SWEEP/DONE are dropped; s_valid=0 for those cycles.

## Timing
- Search latency is 1 cycle: a req sampled at edge N gives s_valid plus the fields after edge N, i.e. during cycle N+1.
- stall=1: all s* outputs hold, and new requests are ignored.
- Read: r_entry reflects r_index one cycle later.
- INVTLB occupies TLBNUM+1 cycles from acceptance to the inv_done pulse.
- inv_req is ignored outside IDLE.
- Reset: all E←0; FSM←IDLE; every output←0. lookup_ready becomes 1 in the first cycle after reset deasserts. Reset during SWEEP aborts the sweep with no inv_done.

## Configuration
- TLB_LOOKUP_WR_FWD_EN defined: a search in the same cycle as a write to a matching index returns the newly written entry.
- Undefined: that search returns the old contents. The new entry is visible from the next request.

## Structure
- tlb_pkg holds:
  - tlb_entry_t and tlb_page_t typedefs
  - PS_4K=6'd12 and PS_4M=6'd22
  - INVTLB op constants and the FSM state enum
- Sub-module tlb_match: combinational per-entry compare (ASID/G/VPPN/PS). It is instantiated TLBNUM×2 for search and once for the sweep.

## Test plan
- Write idx 3 {VPPN=0x00040, PS=12, G=0, ASID=5, P1.PPN=0xABCDE, MAT=1, V=1}; s0 search vaddr=0x00081000, asid=5 → next cycle found=1, index=3, pfn=0xABCDE, ps=12, mat=1.
- Same entry with asid=6 → found=0 and all fields 0. Set G=1 → found=1.
- PS=22 entry VPPN=0x00400, s1 vaddr=0x00800000 → selects P0 and returns found_ps1=22. Duplicate the entry at idx 1 and idx 7 → index=1.
- inv_op=4, inv_asid=5, TLBNUM=16: lookup_ready low for 17 cycles, inv_done on the 17th. G=0/ASID=5 entries are removed; G=1 entries survive. inv_op=7 → inv_err pulse, no state change.
- stall held 3 cycles after a hit → outputs stable. Requests during the stall produce no change.
- Reset asserted mid-sweep → all outputs 0, no inv_done. After release, any search misses.
